// File: rtl/tw_gen_pkg.sv
// ---------------------------------------------------------------------------
// tw_gen_pkg
// Purpose : shared defaults, FSM encoding and helpers for the radix-2 DIF FFT
//           twiddle-factor sequencer (tw_gen) and its ROM (tw_rom).
// Ports   : none (package)
// ---------------------------------------------------------------------------
package tw_gen_pkg;

   // Default FFT geometry and twiddle width
   localparam int unsigned TW_N     = 1024;
   localparam int unsigned TW_LOG2N = 10;
   localparam int unsigned TW_SW    = 4;
   localparam int unsigned TW_W_DEF = 16;

   // Sequencer FSM encoding
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // Symmetric saturation to [-lim, lim]; keeps -2^(W-1) out of the ROM
   function automatic int tw_sat(input int v, input int lim);
      if (v > lim)
         return lim;
      if (v < -lim)
         return -lim;
      return v;
   endfunction

endpackage

// File: rtl/tw_rom.sv
// ---------------------------------------------------------------------------
// tw_rom
// Purpose : twiddle ROM, depth N/2, word {im, re}. Contents are generated at
//           elaboration: re = round(cos(2*pi*k/N)*MAX), im = round(-sin(...)*MAX),
//           MAX = 2^(TW_W-1)-1, both saturated to [-MAX, MAX].
// Ports   : clk      in   clock, rising edge
//           rst      in   asynchronous active-high reset (clears read register)
//           i_rd_en  in   registered read enable
//           i_addr   in   twiddle index k
//           o_data   out  registered word {im, re}
// ---------------------------------------------------------------------------
module tw_rom
   import tw_gen_pkg::*;
#(
   parameter int unsigned  N    = TW_N,
   parameter int unsigned  TW_W = TW_W_DEF,
   localparam int unsigned AW   = $clog2(N / 2)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_rd_en,
   input  logic [AW-1:0]       i_addr,
   output logic [2*TW_W-1:0]   o_data
);

   localparam int unsigned DEPTH = N / 2;
   localparam int          MAXV  = (1 << (TW_W - 1)) - 1;
   localparam real         PI    = 3.14159265358979323846;

   logic [2*TW_W-1:0] w_rom [DEPTH];
   logic [2*TW_W-1:0] r_data;

   // One constant word per index; round half away from zero
   for (genvar g = 0; g < DEPTH; g++) begin : g_word
      localparam real ANG  = 2.0 * PI * real'(g) / real'(N);
      localparam real RE_R = $cos(ANG) * real'(MAXV);
      localparam real IM_R = -$sin(ANG) * real'(MAXV);
      localparam int  RE_I = tw_sat((RE_R >= 0.0) ? $rtoi(RE_R + 0.5) : -$rtoi(0.5 - RE_R), MAXV);
      localparam int  IM_I = tw_sat((IM_R >= 0.0) ? $rtoi(IM_R + 0.5) : -$rtoi(0.5 - IM_R), MAXV);
      assign w_rom[g] = {TW_W'(IM_I), TW_W'(RE_I)};
   end

   // Registered read
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_data <= '0;
      else if (i_rd_en)
         r_data <= w_rom[i_addr];
   end

   assign o_data = r_data;

endmodule

// File: rtl/tw_gen.sv
// ---------------------------------------------------------------------------
// tw_gen
// Purpose : twiddle-factor sequencer for an N-point radix-2 DIF FFT. Issues
//           one W_N^k per butterfly, stage-major / butterfly-minor, tagged with
//           stage and butterfly index, through a 2-stage valid/ready pipeline
//           (P0 = index register, P1 = ROM read register / outputs).
// Ports   : clk           in   clock, rising edge
//           rst           in   asynchronous active-high reset
//           in_start      in   start pulse, sampled only in IDLE
//           in_ready      in   downstream accepts current twiddle
//           out_tw_re     out  twiddle real part, signed Q1.15
//           out_tw_im     out  twiddle imaginary part, signed Q1.15
//           out_tw_valid  out  twiddle/tag outputs valid
//           out_stage     out  stage s of current twiddle
//           out_bfly      out  butterfly index b within stage
//           out_last      out  final twiddle of the run
//           out_busy      out  run in progress
//           out_done      out  one-cycle pulse after final twiddle accepted
// ---------------------------------------------------------------------------
module tw_gen
   import tw_gen_pkg::*;
#(
   parameter int unsigned N     = TW_N,
   parameter int unsigned LOG2N = TW_LOG2N,
   parameter int unsigned SW    = TW_SW,
   parameter int unsigned TW_W  = TW_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_start,
   input  logic             in_ready,
   output logic [TW_W-1:0]  out_tw_re,
   output logic [TW_W-1:0]  out_tw_im,
   output logic             out_tw_valid,
   output logic [SW-1:0]    out_stage,
   output logic [LOG2N-2:0] out_bfly,
   output logic             out_last,
   output logic             out_busy,
   output logic             out_done
);

   localparam int unsigned BW = LOG2N - 1;

   state_t            r_state, w_state_nxt;
   logic [SW-1:0]     r_s;
   logic [BW-1:0]     r_b;
   logic [BW-1:0]     r_k0, r_b0, r_b1;
   logic [SW-1:0]     r_s0, r_s1;
   logic              r_v0, r_v1, r_last0, r_last1;
   logic              r_busy, r_done;
   logic              w_advance, w_issue, w_last_addr, w_accept_last;
   logic [BW-1:0]     w_mask, w_k;
   logic [2*TW_W-1:0] w_rom_data;

   // Pipeline moves whenever the output slot is empty or being consumed
   assign w_advance     = ~r_v1 | in_ready;
   assign w_issue       = w_advance & (((r_state == ST_IDLE) & in_start) | (r_state == ST_RUN));
   assign w_last_addr   = (r_s == SW'(LOG2N - 1)) & (r_b == BW'(N / 2 - 1));
   assign w_accept_last = r_v1 & r_last1 & in_ready;

   // k = (b & ((N >> (s+1)) - 1)) << s
   assign w_mask = BW'((LOG2N'(N / 2) >> r_s) - LOG2N'(1));
   assign w_k    = (r_b & w_mask) << r_s;

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   // FSM next state; DRAIN spans the done cycle so a coincident start is ignored
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE:  if (in_start)                 w_state_nxt = ST_RUN;
         ST_RUN:   if (w_issue && w_last_addr)   w_state_nxt = ST_DRAIN;
         ST_DRAIN: if (r_done)                   w_state_nxt = ST_IDLE;
         default:                                w_state_nxt = ST_IDLE;
      endcase
   end

   // Stage / butterfly counters, advanced once per issued index
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s <= '0;
         r_b <= '0;
      end else if (w_issue) begin
         if (w_last_addr) begin
            r_s <= '0;
            r_b <= '0;
         end else if (r_b == BW'(N / 2 - 1)) begin
            r_b <= '0;
            r_s <= r_s + SW'(1);
         end else begin
            r_b <= r_b + BW'(1);
         end
      end
   end

   // P0 (index + tags) and P1 tags; ROM data register is the P1 twiddle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_v0    <= 1'b0;
         r_k0    <= '0;
         r_s0    <= '0;
         r_b0    <= '0;
         r_last0 <= 1'b0;
         r_v1    <= 1'b0;
         r_s1    <= '0;
         r_b1    <= '0;
         r_last1 <= 1'b0;
      end else if (w_advance) begin
         r_v0    <= w_issue;
         r_k0    <= w_k;
         r_s0    <= r_s;
         r_b0    <= r_b;
         r_last0 <= w_issue & w_last_addr;
         r_v1    <= r_v0;
         r_s1    <= r_s0;
         r_b1    <= r_b0;
         r_last1 <= r_v0 & r_last0;
      end
   end

   // Busy spans start to final acceptance; done pulses right after it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_done <= w_accept_last;
         if ((r_state == ST_IDLE) && in_start)
            r_busy <= 1'b1;
         else if (w_accept_last)
            r_busy <= 1'b0;
      end
   end

   tw_rom #(
      .N    (N),
      .TW_W (TW_W)
   ) u_rom (
      .clk     (clk),
      .rst     (rst),
      .i_rd_en (w_advance),
      .i_addr  (r_k0),
      .o_data  (w_rom_data)
   );

   assign out_tw_re    = w_rom_data[TW_W-1:0];
   assign out_tw_im    = w_rom_data[2*TW_W-1:TW_W];
   assign out_tw_valid = r_v1;
   assign out_stage    = r_s1;
   assign out_bfly     = r_b1;
   assign out_last     = r_last1;
   assign out_busy     = r_busy;
   assign out_done     = r_done;

endmodule
